// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with valid/ready request and response handshakes.
module dmem_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t        r_state, w_next;
    logic          r_alive, r_we, r_uns, r_err;
    logic [1:0]    r_size;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata, r_rdata;
    logic [3:0]    r_cnt;
    logic [31:0]   r_mem [0:(1<<AW)-1];
    logic          w_accept, w_fire, w_err, w_wr, w_unused;
    logic [3:0]    w_be;
    logic [31:0]   w_word, w_lanes, w_load;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // r_alive holds req_ready low until the first edge after reset release
    assign req_ready  = r_state == IDLE && r_alive;
    assign resp_valid = r_state == RESP;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;
    assign w_fire     = r_state == BUSY && r_cnt == 4'd0;
    assign w_err      = r_size == 2'b11 || (r_size == 2'b01 && r_addr[0]) ||
                        (r_size == 2'b00 && r_addr[1:0] != 2'b00);
    assign w_wr       = w_fire && r_we && !w_err;
    assign w_be       = r_size == 2'b00 ? 4'hf :
                        r_size == 2'b01 ? (r_addr[1] ? 4'hc : 4'h3) : 4'b0001 << r_addr[1:0];
    assign w_lanes    = r_size == 2'b00 ? r_wdata :
                        r_size == 2'b01 ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
    assign w_word     = r_mem[r_addr[AW+1:2]];
    assign w_byte     = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = w_word[{r_addr[1], 4'b0000} +: 16];
    assign w_load     = r_size == 2'b00 ? w_word :
                        r_size == 2'b01 ? {{16{~r_uns & w_half[15]}}, w_half} :
                        {{24{~r_uns & w_byte[7]}}, w_byte};
    assign w_unused   = ^req_addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept) w_next = BUSY;
        if (w_fire) w_next = RESP;
        if (r_state == RESP && resp_ready) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire) begin
                r_rdata <= (w_err || r_we) ? '0 : w_load;
                r_err   <= w_err;
            end else if (r_state == RESP && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Array is deliberately unreset; an async reset in BUSY leaves IDLE, so w_wr drops
    always_ff @(posedge clk) begin
        if (w_wr)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= w_lanes[8*i +: 8];
    end
endmodule
